// File: rtl/chan_sel_sequencer_pkg.sv
// Shared constants and state encoding for the channel-select sequencer.
package chan_sel_pkg;

  // Index width is also the downstream one-hot decoder's input width.
  localparam int IDX_W   = 3;
  localparam int N_CH    = 1 << IDX_W;
  localparam int DWELL_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/chan_sel_sequencer_if.sv
// Manual index-load handshake between a controller and the sequencer.
interface chan_sel_sequencer_if;
  import chan_sel_pkg::*;

  logic             load_valid;
  logic [IDX_W-1:0] load_idx;
  logic             load_ready;

  modport master (output load_valid, output load_idx, input load_ready);
  modport slave  (input load_valid, input load_idx, output load_ready);

endinterface

// File: rtl/chan_sel_sequencer_next_enabled_idx.sv
// Finds the first enabled channel after idx, searching upward modulo N_CH.
// Rotating the mask so that bit 0 corresponds to idx+1 turns the circular
// search into a plain lowest-set-bit priority encode.
module next_enabled_idx
  import chan_sel_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic [N_CH-1:0]  mask,
  output logic [IDX_W-1:0] next_idx,
  output logic             wrapped,
  output logic             none
);

  logic [2*N_CH-1:0] mask_x2;
  logic [IDX_W:0]    shamt;
  logic [N_CH-1:0]   rot;
  logic [IDX_W-1:0]  ofs;

  // Rotate, priority-encode the offset, and map it back to an absolute index.
  always_comb begin
    mask_x2 = {mask, mask};
    shamt   = {1'b0, idx} + (IDX_W+1)'(1);
    rot     = mask_x2[shamt +: N_CH];
    ofs     = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (rot[k]) ofs = IDX_W'(k);
    end
    next_idx = idx + IDX_W'(1) + ofs;
    wrapped  = (next_idx <= idx);
    none     = (mask == '0);
  end

endmodule

// File: rtl/chan_sel_sequencer.sv
// Channel-select sequencer: produces the 3-bit index feeding the one-hot
// channel decoder. Scans enabled channels round-robin with a programmable
// dwell (or on explicit steps), accepts manual index loads, and flags
// wrap-around and the no-enabled-channel condition.
module chan_sel_sequencer
  import chan_sel_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 mode,
  input  logic                 step,
  input  logic [N_CH-1:0]      ch_mask,
  input  logic [DWELL_W-1:0]   dwell,
  chan_sel_sequencer_if.slave  load,
  output logic [IDX_W-1:0]     idx,
  output logic                 idx_valid,
  output logic                 wrap,
  output logic                 err,
  output logic                 busy
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               vld_q, vld_d;
  logic               wrap_q, wrap_d;
  logic               err_q, err_d;
  logic               busy_q;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               advance;

  logic [IDX_W-1:0]   search_from;
  logic [IDX_W-1:0]   nx_idx;
  logic               nx_wrapped;
  logic               nx_none;

  // In IDLE the search starts just "before" channel 0 so it returns the
  // lowest enabled channel; in RUN it continues from the current index.
  // The two uses are never needed in the same cycle, so one searcher suffices.
  assign search_from = (state_q == RUN) ? idx_q : IDX_W'(N_CH - 1);

  next_enabled_idx u_next (
    .idx      (search_from),
    .mask     (ch_mask),
    .next_idx (nx_idx),
    .wrapped  (nx_wrapped),
    .none     (nx_none)
  );

  assign load.load_ready = (state_q != RUN);

  assign idx       = idx_q;
  assign idx_valid = vld_q;
  assign wrap      = wrap_q;
  assign err       = err_q;
  assign busy      = busy_q;

  // Next-state and next-output decode; stop outranks start, start outranks load.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (!stop) begin
          if (start) begin
            if (nx_none) begin
              err_d = 1'b1;
            end else begin
              state_d = RUN;
              idx_d   = nx_idx;
              vld_d   = 1'b1;
              cnt_d   = dwell;
            end
          end else if (load.load_valid) begin
            state_d = HOLD;
            idx_d   = load.load_idx;
            vld_d   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end else if (start) begin
          state_d = RUN;
          cnt_d   = dwell;
        end else if (load.load_valid) begin
          idx_d = load.load_idx;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end else begin
          // Auto mode holds each channel dwell+1 cycles; step mode ignores cnt.
          advance = mode ? step : (cnt_q == '0);
          if (!mode && cnt_q != '0) cnt_d = cnt_q - DWELL_W'(1);
          if (advance) begin
            if (nx_none) begin
              state_d = IDLE;
              vld_d   = 1'b0;
              err_d   = 1'b1;
            end else begin
              idx_d  = nx_idx;
              wrap_d = nx_wrapped;
              if (!mode) cnt_d = dwell;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  // State, dwell counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      busy_q  <= (state_d == RUN);
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_chan_sel_sequencer.sv
// Directed bench for chan_sel_sequencer: hand-written scan sequences plus a
// table of per-cycle {inputs, expected outputs} records.
module tb_chan_sel_sequencer;
  import chan_sel_pkg::*;

  logic               clk = 1'b0;
  logic               rst, start, stop, mode, step;
  logic [N_CH-1:0]    ch_mask;
  logic [DWELL_W-1:0] dwell;
  logic [IDX_W-1:0]   idx;
  logic               idx_valid, wrap, err, busy;

  chan_sel_sequencer_if lif ();

  chan_sel_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .step      (step),
    .ch_mask   (ch_mask),
    .dwell     (dwell),
    .load      (lif.slave),
    .idx       (idx),
    .idx_valid (idx_valid),
    .wrap      (wrap),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic           rst, start, stop, mode, step;
    logic [7:0]     mask;
    logic [7:0]     dwell;
    logic           lv;
    logic [2:0]     li;
    logic [2:0]     e_idx;
    logic           e_vld, e_wrap, e_err, e_busy, e_lr;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  task automatic chk_out(input string nm, input int e_idx, input int e_vld,
                         input int e_wrap, input int e_err, input int e_busy,
                         input int e_lr);
    chk({nm, ".idx"},        int'(idx),            e_idx);
    chk({nm, ".idx_valid"},  int'(idx_valid),      e_vld);
    chk({nm, ".wrap"},       int'(wrap),           e_wrap);
    chk({nm, ".err"},        int'(err),            e_err);
    chk({nm, ".busy"},       int'(busy),           e_busy);
    chk({nm, ".load_ready"}, int'(lif.load_ready), e_lr);
  endtask

  task automatic add(input string nm, input logic r, input logic sa, input logic so,
                     input logic md, input logic st, input logic [7:0] mk,
                     input logic [7:0] dw, input logic lv, input logic [2:0] li,
                     input logic [2:0] ei, input logic ev, input logic ew,
                     input logic ee, input logic eb, input logic el);
    vec_t v;
    v.name = nm; v.rst = r; v.start = sa; v.stop = so; v.mode = md; v.step = st;
    v.mask = mk; v.dwell = dw; v.lv = lv; v.li = li;
    v.e_idx = ei; v.e_vld = ev; v.e_wrap = ew; v.e_err = ee; v.e_busy = eb; v.e_lr = el;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; step = 1'b0;
    ch_mask = '0; dwell = '0;
    lif.load_valid = 1'b0; lif.load_idx = '0;

    // Reset values.
    tick();
    tick();
    rst = 1'b0;
    chk_out("reset", 0, 0, 0, 0, 0, 1);

    // Full mask, dwell=2: each channel live 3 cycles, single wrap on 7->0.
    ch_mask = 8'hFF; dwell = 8'd2; mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_start.busy", int'(busy), 1);
    chk("t1_start.idx_valid", int'(idx_valid), 1);
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < 3; r++) begin
        chk($sformatf("t1_ch%0d_r%0d.idx", c, r), int'(idx), c);
        chk($sformatf("t1_ch%0d_r%0d.wrap", c, r), int'(wrap), 0);
        tick();
      end
    end
    chk_out("t1_wrap", 0, 1, 1, 0, 1, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_out("t1_stop", 0, 0, 0, 0, 0, 1);

    // Step mode: dwell=0 would advance every cycle in auto mode, so any
    // movement between steps means the counter was not ignored.
    mode = 1'b1; dwell = 8'd0; ch_mask = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("t3_start", 0, 1, 0, 0, 1, 0);
    for (int i = 1; i <= 9; i++) begin
      step = (i == 3 || i == 7);
      tick();
      chk($sformatf("t3_cyc%0d.idx", i), int'(idx), (i >= 7) ? 2 : (i >= 3) ? 1 : 0);
      chk($sformatf("t3_cyc%0d.wrap", i), int'(wrap), 0);
    end
    step = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    mode = 1'b0;
    chk_out("t3_stop", 2, 0, 0, 0, 0, 1);

    //   name          rst sa so md st mask   dw  lv li  idx v  w  e  b  lr
    add("t2_start",    0, 1, 0, 0, 0, 8'hA4, 0, 0, 0,  2, 1, 0, 0, 1, 0);
    add("t2_adv5",     0, 0, 0, 0, 0, 8'hA4, 0, 0, 0,  5, 1, 0, 0, 1, 0);
    add("t2_adv7",     0, 0, 0, 0, 0, 8'hA4, 0, 0, 0,  7, 1, 0, 0, 1, 0);
    add("t2_wrap2",    0, 0, 0, 0, 0, 8'hA4, 0, 0, 0,  2, 1, 1, 0, 1, 0);
    add("t2_adv5b",    0, 0, 0, 0, 0, 8'hA4, 0, 0, 0,  5, 1, 0, 0, 1, 0);
    add("t2_stop",     0, 0, 1, 0, 0, 8'hA4, 0, 0, 0,  5, 0, 0, 0, 0, 1);
    add("t4_load6",    0, 0, 0, 0, 0, 8'hFF, 1, 1, 6,  6, 1, 0, 0, 0, 1);
    add("t4_hold",     0, 0, 0, 0, 0, 8'hFF, 1, 0, 0,  6, 1, 0, 0, 0, 1);
    add("t4_start",    0, 1, 0, 0, 0, 8'hFF, 1, 0, 0,  6, 1, 0, 0, 1, 0);
    add("t4_dw6",      0, 0, 0, 0, 0, 8'hFF, 1, 0, 0,  6, 1, 0, 0, 1, 0);
    add("t4_adv7",     0, 0, 0, 0, 0, 8'hFF, 1, 0, 0,  7, 1, 0, 0, 1, 0);
    add("t4_dw7",      0, 0, 0, 0, 0, 8'hFF, 1, 0, 0,  7, 1, 0, 0, 1, 0);
    add("t4_wrap0",    0, 0, 0, 0, 0, 8'hFF, 1, 0, 0,  0, 1, 1, 0, 1, 0);
    add("t4_ld_run",   0, 0, 0, 0, 0, 8'hFF, 1, 1, 3,  0, 1, 0, 0, 1, 0);
    add("t4_adv1",     0, 0, 0, 0, 0, 8'hFF, 1, 0, 0,  1, 1, 0, 0, 1, 0);
    add("t4_stop",     0, 0, 1, 0, 0, 8'hFF, 1, 0, 0,  1, 0, 0, 0, 0, 1);
    add("t5_err",      0, 1, 0, 0, 0, 8'h00, 1, 0, 0,  1, 0, 0, 1, 0, 1);
    add("t5_idle",     0, 0, 0, 0, 0, 8'h00, 1, 0, 0,  1, 0, 0, 0, 0, 1);
    add("t5_run",      0, 1, 0, 0, 0, 8'hFF, 1, 0, 0,  0, 1, 0, 0, 1, 0);
    add("t5_clr",      0, 0, 0, 0, 0, 8'h00, 1, 0, 0,  0, 1, 0, 0, 1, 0);
    add("t5_adv_err",  0, 0, 0, 0, 0, 8'h00, 1, 0, 0,  0, 0, 0, 1, 0, 1);
    add("t5_after",    0, 0, 0, 0, 0, 8'h00, 1, 0, 0,  0, 0, 0, 0, 0, 1);
    add("t6_ld4",      0, 0, 0, 0, 0, 8'hFF, 0, 1, 4,  4, 1, 0, 0, 0, 1);
    add("t6_stop_ld",  0, 0, 1, 0, 0, 8'hFF, 0, 1, 5,  4, 0, 0, 0, 0, 1);
    add("t6_ss_idle",  0, 1, 1, 0, 0, 8'hFF, 0, 0, 0,  4, 0, 0, 0, 0, 1);
    add("t6_run",      0, 1, 0, 0, 0, 8'hFF, 0, 0, 0,  0, 1, 0, 0, 1, 0);
    add("t6_r1",       0, 0, 0, 0, 0, 8'hFF, 0, 0, 0,  1, 1, 0, 0, 1, 0);
    add("t6_r2",       0, 0, 0, 0, 0, 8'hFF, 0, 0, 0,  2, 1, 0, 0, 1, 0);
    add("t6_rst",      1, 0, 0, 0, 0, 8'hFF, 0, 0, 0,  0, 0, 0, 0, 0, 1);
    add("t6_post",     0, 0, 0, 0, 0, 8'hFF, 0, 0, 0,  0, 0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      rst            = vecs[i].rst;
      start          = vecs[i].start;
      stop           = vecs[i].stop;
      mode           = vecs[i].mode;
      step           = vecs[i].step;
      ch_mask        = vecs[i].mask;
      dwell          = vecs[i].dwell;
      lif.load_valid = vecs[i].lv;
      lif.load_idx   = vecs[i].li;
      tick();
      chk_out(vecs[i].name, int'(vecs[i].e_idx), int'(vecs[i].e_vld),
              int'(vecs[i].e_wrap), int'(vecs[i].e_err), int'(vecs[i].e_busy),
              int'(vecs[i].e_lr));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
